score_bcd_display: RTL and testbench

//  Parametrised multi-digit score display driver. Accepts a binary score with a valid strobe and

---
 rtl/score_display_pkg.sv | 29 ++
 rtl/score_bcd_display_seg7.sv | 18 +
 rtl/score_bcd_display.sv | 178 +++++++++++++++++
 tb/tb_score_bcd_display.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// score_display_pkg: shared constants for the BCD score display.
// Holds the seven-segment lookup table, the blank pattern, the FSM state
// encoding and a polarity-aware single-digit encode helper.
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Segment order A..G maps to bits [6]..[0]; values are active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

  // Encode one BCD nibble; blank or out-of-range nibbles give an unlit digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd,
                                            input logic       blank,
                                            input bit         active_low);
    logic [6:0] seg;
    if (blank || (bcd > 4'd9)) seg = SEG_BLANK;
    else                       seg = SEG_LUT[bcd];
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/score_bcd_display_seg7.sv
// seg7_digit_encoder: combinational BCD nibble to seven-segment pattern,
// with a blank override and selectable output polarity.
module seg7_digit_encoder
  import score_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_Bcd,
  input  logic       i_Blank,
  output logic [6:0] o_Seg
);

  // Pure lookup; no state held here.
  always_comb begin
    o_Seg = seg_encode(i_Bcd, i_Blank, SEG_ACTIVE_LOW);
  end

endmodule

// File: rtl/score_bcd_display.sv
// score_bcd_display: binary score to multi-digit seven-segment driver.
// Sequential double-dabble (one shift per clock), one-entry pending buffer
// for updates that arrive while a conversion is running, registered
// segment bus that only changes on the UPDATE edge.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module score_bcd_display
  import score_display_pkg::*;
#(
  parameter int WIDTH          = 7,
  parameter int DIGITS         = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Valid,
  input  logic [WIDTH-1:0]      i_Score,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Overflow,
  output logic [7*DIGITS-1:0]   o_Segments
);

  localparam int          BCD_W     = 4 * DIGITS;
  localparam int          CNT_W     = $clog2(WIDTH + 1);
  localparam int unsigned MAX_SCORE = 10 ** DIGITS - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_bin;
  logic [BCD_W-1:0]     r_bcd;
  logic [BCD_W-1:0]     w_bcd_adj;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf;
  logic                 r_pend_vld;
  logic [WIDTH-1:0]     r_pend_score;
  logic                 r_done;
  logic                 r_overflow;
  logic [7*DIGITS-1:0]  r_seg;

  logic                 w_busy;
  logic                 w_load;
  logic [WIDTH-1:0]     w_load_score;
  logic                 w_load_ovf;
  logic [DIGITS-1:0]    w_blank;
  logic [7*DIGITS-1:0]  w_enc_seg;
  logic [7*DIGITS-1:0]  w_rst_seg;
  logic [7*DIGITS-1:0]  w_nine_seg;

  // A buffered score always takes priority over a fresh strobe in IDLE.
  assign w_load       = (r_state == ST_IDLE) && (r_pend_vld || i_Valid);
  assign w_load_score = r_pend_vld ? r_pend_score : i_Score;
  assign w_load_ovf   = (32'(w_load_score) > MAX_SCORE);

  // State register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> SHIFT (WIDTH cycles) -> UPDATE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (r_pend_vld || i_Valid) w_state_nxt = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == LAST_CNT)     w_state_nxt = ST_UPDATE;
      ST_UPDATE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_busy = 1'b0;
    if ((r_state == ST_SHIFT) || (r_state == ST_UPDATE)) w_busy = 1'b1;
  end

  assign o_Busy = w_busy;

  // Double-dabble correction: bump every nibble >= 5 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
  end

  // Conversion datapath: load on accept, shift once per SHIFT cycle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_bin <= w_load_score;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= w_load_ovf;
          end
        end
        ST_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pending buffer: strobes that cannot be accepted now are parked here,
  // newest overwriting any older parked score.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_pend_vld   <= 1'b0;
      r_pend_score <= '0;
    end else if (i_Valid && (w_busy || r_pend_vld)) begin
      r_pend_vld   <= 1'b1;
      r_pend_score <= i_Score;
    end else if (w_load) begin
      r_pend_vld   <= 1'b0;
    end
  end

  // Leading-zero blanking: a non-units digit is blank when it and every
  // digit above it are zero.
  always_comb begin
    logic zero_above;
    w_blank    = '0;
    zero_above = LZB_EN;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_blank[d] = zero_above && (r_bcd[4*d +: 4] == 4'd0);
      zero_above = w_blank[d];
    end
  end

  // Per-digit encoders plus the constant reset and overflow patterns.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    seg7_digit_encoder #(
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_enc (
      .i_Bcd   (r_bcd[4*d +: 4]),
      .i_Blank (w_blank[d]),
      .o_Seg   (w_enc_seg[7*d +: 7])
    );
    assign w_rst_seg[7*d +: 7]  = seg_encode(4'd0, LZB_EN && (d != 0), SEG_ACTIVE_LOW);
    assign w_nine_seg[7*d +: 7] = seg_encode(4'd9, 1'b0, SEG_ACTIVE_LOW);
  end

  // Output registers: segments and overflow only move on the UPDATE edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_seg      <= w_rst_seg;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= (r_state == ST_UPDATE);
      if (r_state == ST_UPDATE) begin
        r_seg      <= r_ovf ? w_nine_seg : w_enc_seg;
        r_overflow <= r_ovf;
      end
    end
  end

  assign o_Done     = r_done;
  assign o_Overflow = r_overflow;
  assign o_Segments = r_seg;

endmodule

// File: tb/tb_score_bcd_display.sv
// tb_score_bcd_display: self-checking bench for score_bcd_display
// (WIDTH=7, DIGITS=2, active-low segments). Expected displays come from
// decimal arithmetic on the score, not from the converter's structure.
module tb_score_bcd_display;

  localparam int WIDTH  = 7;
  localparam int DIGITS = 2;
  localparam int MAXV   = 10 ** DIGITS - 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_l;
  logic                 valid;
  logic [WIDTH-1:0]     score;
  logic                 busy;
  logic                 done;
  logic                 ovf;
  logic [7*DIGITS-1:0]  segs;

  int n_cmp = 0;
  int n_err = 0;
  logic [7*DIGITS-1:0] exp_disp;
  logic [6:0] tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                           7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  score_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_l),
    .i_Valid    (valid),
    .i_Score    (score),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Overflow (ovf),
    .o_Segments (segs)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Display expected for a score: decimal digits, 9s on overflow,
  // optional blanking of digits above the score's magnitude.
  function automatic logic [7*DIGITS-1:0] model_seg(int s);
    logic [7*DIGITS-1:0] r;
    logic [6:0] g;
    int p, nib;
    bit blank;
    p = 1;
    r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      nib   = (s > MAXV) ? 9 : (s / p) % 10;
      blank = LZB && (d > 0) && (s <= MAXV) && (s < p);
      g     = blank ? 7'h00 : tab[nib];
      r[7*d +: 7] = ~g;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_l = 1'b0; valid = 1'b0; score = '0;
    tick(); tick();
    rst_l = 1'b1;
    exp_disp = model_seg(0);
    n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL reset_segs: got %h want %h", segs, exp_disp); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_single(input int s);
    int lat;
    bit seen;
    valid = 1'b1; score = WIDTH'(s);
    tick();
    valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy s=%0d: got %b want 1", s, busy); end
    seen = 1'b0; lat = 0;
    for (int c = 1; c <= WIDTH + 6 && !seen; c++) begin
      tick();
      if (done) begin
        seen = 1'b1; lat = c;
      end else begin
        n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL single_hold s=%0d c=%0d: got %h want %h", s, c, segs, exp_disp); end
      end
    end
    n_cmp++; if (lat !== WIDTH + 1) begin n_err++; $display("FAIL single_latency s=%0d: got %0d want %0d", s, lat, WIDTH + 1); end
    exp_disp = model_seg(s);
    n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL single_segs s=%0d: got %h want %h", s, segs, exp_disp); end
    n_cmp++; if (ovf !== (s > MAXV)) begin n_err++; $display("FAIL single_ovf s=%0d: got %b want %b", s, ovf, s > MAXV); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle s=%0d: got %b want 0", s, busy); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_pulse s=%0d: got %b want 0", s, done); end
    n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL single_after s=%0d: got %h want %h", s, segs, exp_disp); end
  endtask

  // First score accepted, then strobes at chosen offsets while busy;
  // only the first and the newest parked score may ever be shown.
  task automatic test_back_to_back(input int first, input bit directed);
    bit en [WIDTH + 2];
    int val [WIDTH + 2];
    int last, n_done, any;
    for (int k = 0; k < WIDTH + 2; k++) begin
      en[k]  = directed ? 1'b0 : ($urandom_range(0, 2) == 0);
      val[k] = $urandom_range(0, 2 ** WIDTH - 1);
    end
    en[0] = 1'b0;
    if (directed) begin
      en[2] = 1'b1; val[2] = 99;
      en[5] = 1'b1; val[5] = 55;
    end
    any = 0;
    for (int k = 1; k <= WIDTH + 1; k++) if (en[k]) any = 1;
    if (any == 0) en[$urandom_range(1, WIDTH + 1)] = 1'b1;
    last = 0;
    for (int k = 1; k <= WIDTH + 1; k++) if (en[k]) last = val[k];

    valid = 1'b1; score = WIDTH'(first);
    tick();
    n_done = 0;
    for (int c = 1; c <= 2 * WIDTH + 8; c++) begin
      valid = (c <= WIDTH + 1) && en[c];
      score = WIDTH'(val[(c <= WIDTH + 1) ? c : 0]);
      tick();
      valid = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          exp_disp = model_seg(first);
          n_cmp++; if (c !== WIDTH + 1) begin n_err++; $display("FAIL b2b_lat1: got %0d want %0d", c, WIDTH + 1); end
          n_cmp++; if (ovf !== (first > MAXV)) begin n_err++; $display("FAIL b2b_ovf1: got %b want %b", ovf, first > MAXV); end
        end else begin
          exp_disp = model_seg(last);
          n_cmp++; if (c !== 2 * WIDTH + 3) begin n_err++; $display("FAIL b2b_lat2: got %0d want %0d", c, 2 * WIDTH + 3); end
          n_cmp++; if (ovf !== (last > MAXV)) begin n_err++; $display("FAIL b2b_ovf2: got %b want %b", ovf, last > MAXV); end
        end
        n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL b2b_segs%0d: got %h want %h", n_done, segs, exp_disp); end
      end else begin
        n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL b2b_hold c=%0d: got %h want %h", c, segs, exp_disp); end
      end
    end
    n_cmp++; if (n_done !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
  endtask

  task automatic test_reset_mid();
    int n_done;
    valid = 1'b1; score = WIDTH'(42);
    tick();
    valid = 1'b0;
    tick(); tick();
    rst_l = 1'b0;
    tick();
    exp_disp = model_seg(0);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL midrst_segs: got %h want %h", segs, exp_disp); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    rst_l = 1'b1;
    n_done = 0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      tick();
      if (done) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", n_done); end
    n_cmp++; if (segs !== exp_disp) begin n_err++; $display("FAIL midrst_hold: got %h want %h", segs, exp_disp); end
  endtask

  initial begin
    rst_l = 1'b0; valid = 1'b0; score = '0;
    exp_disp = '0;
    test_reset();
    test_single(42);
    test_single(127);
    test_single(5);
    test_single(9);
    test_single(10);
    test_single(0);
    test_single(99);
    test_single(100);
    test_back_to_back(10, 1'b1);
    for (int i = 0; i < 5; i++) test_back_to_back($urandom_range(0, 2 ** WIDTH - 1), 1'b0);
    for (int i = 0; i < 20; i++) test_single($urandom_range(0, 2 ** WIDTH - 1));
    test_single(55);
    test_reset_mid();
    test_single(73);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
